multiplier_key_conditioner: RTL

Input conditioner that sits directly upstream of the 8-bit multiplier. It synchronizes and debounces the two raw active-low push buttons (Run and Clear/Load) and emits clean single-cycle start/load pulses. It captures an operand from the slide switches and holds off a Run request while the multiplier reports Busy, queuing at most one request. Its outputs drive the multiplier's Run, load and Switches inputs directly.

---
 rtl/multiplier_key_conditioner.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/multiplier_key_conditioner.sv
// Key conditioner in front of the 8-bit multiplier: synchronizes and debounces
// the Run and Clear/Load buttons, captures the switch operand, and queues one Run behind Busy.

module mkc_key_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  logic          s1_q, s2_q;
  logic          stable_q, stable_d;
  logic          prev_q;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          lvl;

  // Raw key is active-low; synced pressed level is 1.
  assign lvl = ~s2_q;

  // A mismatch must persist for DEBOUNCE_CYCLES cycles; any agreement restarts the count.
  always_comb begin
    cnt_inc  = cnt_q + 1'b1;
    cnt_d    = '0;
    stable_d = stable_q;
    if (lvl != stable_q) begin
      if (cnt_inc == CNT_MAX) stable_d = lvl;
      else                    cnt_d    = cnt_inc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q     <= 1'b1;
      s2_q     <= 1'b1;
      stable_q <= 1'b0;
      prev_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      s1_q     <= key_n;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      prev_q   <= stable_q;
      cnt_q    <= cnt_d;
    end
  end

  assign press = stable_q & ~prev_q;
endmodule

module multiplier_key_conditioner #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run_key,
  input  logic       Load_key,
  input  logic [7:0] Switches,
  input  logic       Busy,
  output logic       Run_pulse,
  output logic       Load_pulse,
  output logic [7:0] Operand,
  output logic       Pending
);
  localparam int NUM_KEYS = 2;
  localparam int KEY_RUN  = 0;
  localparam int KEY_LOAD = 1;

  typedef enum logic {IDLE, QUEUED} run_state_e;

  logic [NUM_KEYS-1:0] key_n, press;
  logic [7:0]          sw_s1_q, sw_s2_q;
  logic [7:0]          operand_q, operand_d;
  logic                load_pulse_q, load_pulse_d;
  logic                load_acc, run_ev;
  run_state_e          state_q;
  logic                run_pulse_q, pending_q;

  assign key_n = {Load_key, Run_key};

  generate
    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
      mkc_key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
        .clk   (Clk),
        .rst_n (Reset),
        .key_n (key_n[i]),
        .press (press[i])
      );
    end
  endgenerate

  assign run_ev   = press[KEY_RUN];
  assign load_acc = press[KEY_LOAD] & ~Busy;

  always_comb begin
    load_pulse_d = load_acc;
    operand_d    = load_acc ? sw_s2_q : operand_q;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      sw_s1_q      <= '0;
      sw_s2_q      <= '0;
      operand_q    <= '0;
      load_pulse_q <= 1'b0;
    end else begin
      sw_s1_q      <= Switches;
      sw_s2_q      <= sw_s1_q;
      operand_q    <= operand_d;
      load_pulse_q <= load_pulse_d;
    end
  end

  // A Run that collides with an accepted Load is deferred one cycle so the
  // two strobes never overlap; the same guard applies when draining QUEUED.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= IDLE;
      run_pulse_q <= 1'b0;
      pending_q   <= 1'b0;
    end else begin
      run_pulse_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (run_ev) begin
            if (Busy || load_acc) begin
              state_q   <= QUEUED;
              pending_q <= 1'b1;
            end else begin
              run_pulse_q <= 1'b1;
            end
          end
        end
        QUEUED: begin
          if (!Busy && !load_acc) begin
            run_pulse_q <= 1'b1;
            state_q     <= IDLE;
            pending_q   <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          pending_q <= 1'b0;
        end
      endcase
    end
  end

  assign Run_pulse  = run_pulse_q;
  assign Load_pulse = load_pulse_q;
  assign Operand    = operand_q;
  assign Pending    = pending_q;
endmodule
